// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if
//   Bundles the signals of the SPI master arbiter. On one side are the
//   requesters: their request/response handshake and per-requester SPI mode.
//   On the other side is the shared spi_master_top: its config, data, enable,
//   done and chip select.
//
//   modport master : the arbiter's view. It accepts requests, drives the SPI
//                    master and drives the per-device chip selects.
//   modport slave  : the environment's view. It covers the requesters, the SPI
//                    master core and the devices.
//
//   Requester side : i_req_valid, o_req_ready, i_req_data, i_req_cpol,
//                    i_req_cpha, i_req_divider, o_rsp_valid, o_rsp_data
//   Master side    : o_master_enable, o_master_cpol, o_master_cpha,
//                    o_master_divider, o_master_data, i_master_data,
//                    i_master_done, i_master_cs_n
//   Status/devices : o_cs_n, o_busy, o_grant_id
interface spi_master_arbiter_if #(
    parameter int NUM_REQ                 = 2,
    parameter int SPI_DATA_WIDTH          = 8,
    parameter int SPI_CLOCK_DIVIDER_WIDTH = 4
);
    localparam int GRANT_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                         i_req_valid;
    logic [NUM_REQ-1:0]                         o_req_ready;
    logic [NUM_REQ*SPI_DATA_WIDTH-1:0]          i_req_data;
    logic [NUM_REQ-1:0]                         i_req_cpol;
    logic [NUM_REQ-1:0]                         i_req_cpha;
    logic [NUM_REQ*SPI_CLOCK_DIVIDER_WIDTH-1:0] i_req_divider;
    logic [NUM_REQ-1:0]                         o_rsp_valid;
    logic [SPI_DATA_WIDTH-1:0]                  o_rsp_data;

    logic                                       o_master_enable;
    logic                                       o_master_cpol;
    logic                                       o_master_cpha;
    logic [SPI_CLOCK_DIVIDER_WIDTH-1:0]         o_master_divider;
    logic [SPI_DATA_WIDTH-1:0]                  o_master_data;
    logic [SPI_DATA_WIDTH-1:0]                  i_master_data;
    logic                                       i_master_done;
    logic                                       i_master_cs_n;

    logic [NUM_REQ-1:0]                         o_cs_n;
    logic                                       o_busy;
    logic [GRANT_WIDTH-1:0]                     o_grant_id;

    modport master (
        input  i_req_valid, i_req_data, i_req_cpol, i_req_cpha, i_req_divider,
        output o_req_ready, o_rsp_valid, o_rsp_data,
        output o_master_enable, o_master_cpol, o_master_cpha, o_master_divider, o_master_data,
        input  i_master_data, i_master_done, i_master_cs_n,
        output o_cs_n, o_busy, o_grant_id
    );

    modport slave (
        output i_req_valid, i_req_data, i_req_cpol, i_req_cpha, i_req_divider,
        input  o_req_ready, o_rsp_valid, o_rsp_data,
        input  o_master_enable, o_master_cpol, o_master_cpha, o_master_divider, o_master_data,
        output i_master_data, i_master_done, i_master_cs_n,
        input  o_cs_n, o_busy, o_grant_id
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//   Shares one spi_master_top between NUM_REQ requesters. Each requester has
//   its own CPOL/CPHA, clock divider and chip select. Arbitration is
//   round-robin, decided once per transaction. The arbiter captures the
//   winner's request and drives the master's config, data and enable. It
//   returns o_data_out to the winner when o_done arrives, and routes the
//   master's chip select to the granted device.
//
//   Optional build macro SPI_ARB_PRIORITY_EN: when defined, requester 0 wins
//   whenever it is valid, and the other requesters share round-robin among
//   themselves. When undefined, round-robin runs over all requesters.
//
// Ports
//   i_clock  : system clock
//   i_reset  : synchronous, active-high reset
//   bus      : spi_master_arbiter_if.master. It carries the requester
//              handshake, the shared-master controls and status, and the
//              per-device chip selects.
//
// States
//   state    | meaning
//   IDLE     | waiting for any request; o_req_ready to the winner
//   SETUP    | latched config on master inputs, one settle cycle
//   START    | o_master_enable pulse
//   BUSY     | transfer in progress, waiting for i_master_done
//   GAP      | minimum deselect time before the next grant
module spi_master_arbiter #(
    parameter int NUM_REQ                 = 2,
    parameter int SPI_DATA_WIDTH          = 8,
    parameter int SPI_CLOCK_DIVIDER_WIDTH = 4,
    parameter int GAP_CYCLES              = 4
) (
    input logic                  i_clock,
    input logic                  i_reset,
    spi_master_arbiter_if.master bus
);
    localparam int GRANT_W = $clog2(NUM_REQ);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

`ifdef SPI_ARB_PRIORITY_EN
    localparam bit PRIORITY_EN = 1'b1;
`else
    localparam bit PRIORITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_BUSY,
        ST_GAP
    } state_t;

    state_t                             state_q;
    state_t                             state_d;
    logic [GRANT_W-1:0]                 rr_ptr_q;
    logic [GRANT_W-1:0]                 grant_q;
    logic [GRANT_W-1:0]                 win_idx;
    logic                               win_found;
    int                                 cand;
    logic [SPI_DATA_WIDTH-1:0]          data_q;
    logic [SPI_DATA_WIDTH-1:0]          rsp_data_q;
    logic                               cpol_q;
    logic                               cpha_q;
    logic [SPI_CLOCK_DIVIDER_WIDTH-1:0] div_q;
    logic [NUM_REQ-1:0]                 rsp_valid_q;
    logic [GAP_W-1:0]                   gap_cnt_q;
    logic                               accept;

    // Search starts just after the last winner. With priority enabled,
    // requester 0 is taken out of the rotation and checked first instead.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (PRIORITY_EN && bus.i_req_valid[0]) begin
            win_found = 1'b1;
        end
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!win_found && !(PRIORITY_EN && cand == 0) && bus.i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = GRANT_W'(cand);
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && win_found;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (win_found) state_d = ST_SETUP;
            ST_SETUP: state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY:  if (bus.i_master_done) state_d = ST_GAP;
            // Also wait for done to drop, so a stretched done cannot overlap the next enable.
            ST_GAP:   if (gap_cnt_q == '0 && !bus.i_master_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rr_ptr_q    <= GRANT_W'(NUM_REQ - 1);
            grant_q     <= '0;
            data_q      <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            div_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (accept) begin
                rr_ptr_q <= win_idx;
                grant_q  <= win_idx;
                data_q   <= bus.i_req_data[win_idx*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
                cpol_q   <= bus.i_req_cpol[win_idx];
                cpha_q   <= bus.i_req_cpha[win_idx];
                div_q    <= bus.i_req_divider[win_idx*SPI_CLOCK_DIVIDER_WIDTH +: SPI_CLOCK_DIVIDER_WIDTH];
            end
            if (state_q == ST_BUSY && bus.i_master_done) begin
                rsp_data_q  <= bus.i_master_data;
                rsp_valid_q <= NUM_REQ'(1) << grant_q;
                gap_cnt_q   <= GAP_W'(GAP_CYCLES);
            end else if (state_q == ST_GAP && gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
            end
        end
    end

    // Only the granted device can see a low chip select. The reset gate keeps
    // all devices deselected while a transfer is being aborted.
    always_comb begin
        bus.o_cs_n = '1;
        if (state_q != ST_IDLE && !i_reset) begin
            bus.o_cs_n[grant_q] = bus.i_master_cs_n;
        end
    end

    assign bus.o_req_ready      = (accept && !i_reset) ? (NUM_REQ'(1) << win_idx) : '0;
    assign bus.o_rsp_valid      = rsp_valid_q;
    assign bus.o_rsp_data       = rsp_data_q;
    assign bus.o_master_enable  = (state_q == ST_START);
    assign bus.o_master_cpol    = cpol_q;
    assign bus.o_master_cpha    = cpha_q;
    assign bus.o_master_divider = div_q;
    assign bus.o_master_data    = data_q;
    assign bus.o_busy           = (state_q != ST_IDLE);
    assign bus.o_grant_id       = grant_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
module tb_spi_master_arbiter;
    localparam int N   = 2;
    localparam int DW  = 8;
    localparam int CW  = 4;
    localparam int GAP = 4;
    localparam int NEVER = 1 << 30;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    spi_master_arbiter_if #(.NUM_REQ(N), .SPI_DATA_WIDTH(DW), .SPI_CLOCK_DIVIDER_WIDTH(CW)) bus ();

    spi_master_arbiter #(
        .NUM_REQ(N), .SPI_DATA_WIDTH(DW), .SPI_CLOCK_DIVIDER_WIDTH(CW), .GAP_CYCLES(GAP)
    ) dut (
        .i_clock(clock),
        .i_reset(reset),
        .bus(bus)
    );

    typedef struct {
        int          id;
        logic [7:0]  data;
        bit          cpol;
        bit          cpha;
        logic [3:0]  div;
        int          acc_cyc;
    } cfg_t;

    typedef struct {
        int          id;
        logic [7:0]  rx;
    } rsp_t;

    cfg_t cfg_q[$];
    rsp_t rsp_q[$];
    int   grant_log[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // requester state
    bit         pend[N];
    bit         acc[N];
    int         remaining[N];
    logic [7:0] r_data[N];
    bit         r_cpol[N];
    bit         r_cpha[N];
    logic [3:0] r_div[N];
    bit         rand_mode = 1'b0;

    // reference arbiter view
    int rr_ptr      = N - 1;
    int arb_idle_at = 0;
    int cur_grant   = 0;

    // master/slave model state
    bit         mm_busy = 1'b0;
    int         mm_cnt  = 0;
    logic [7:0] mm_tx;
    bit         mm_cpol;
    bit         mm_cpha;
    logic [3:0] mm_div;
    int         last_done_cyc = -100;
    cfg_t       mm_exp;
    rsp_t       mon_exp;

    always @(posedge clock) cyc = cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    // Round-robin rule: first valid requester after the previous winner.
    function automatic int rr_pick(input bit v[N], input int ptr);
        int c;
`ifdef SPI_ARB_PRIORITY_EN
        if (v[0]) return 0;
`endif
        for (int i = 1; i <= N; i++) begin
            c = (ptr + i) % N;
`ifdef SPI_ARB_PRIORITY_EN
            if (c != 0 && v[c]) return c;
`else
            if (v[c]) return c;
`endif
        end
        return -1;
    endfunction

    // SPI master + slave model: the slave answers with the complement of the
    // transmitted byte, which gives 0x69 for 0x96.
    always @(negedge clock) begin
        if (reset) begin
            mm_busy           = 1'b0;
            bus.i_master_cs_n = 1'b1;
            bus.i_master_done = 1'b0;
            bus.i_master_data = '0;
        end else begin
            if (bus.i_master_done) bus.i_master_done = 1'b0;
            if (mm_busy) begin
                bus.i_master_cs_n = 1'b0;
                mm_cnt--;
                if (mm_cnt == 0) begin
                    bus.i_master_done = 1'b1;
                    bus.i_master_data = ~mm_tx;
                    bus.i_master_cs_n = 1'b1;
                    mm_busy           = 1'b0;
                    last_done_cyc     = cyc;
                    arb_idle_at       = cyc + GAP + 2;
                end
            end
            if (bus.o_master_enable) begin
                chk("enable_while_busy", mm_busy, 1'b0);
                chk("enable_while_done", bus.i_master_done, 1'b0);
                chk("gap_before_enable", (cyc - (last_done_cyc + 1)) >= GAP, 1'b1);
                if (cfg_q.size() == 0) begin
                    chk("enable_unexpected", 1'b1, 1'b0);
                end else begin
                    mm_exp = cfg_q.pop_front();
                    chk("enable_latency", cyc, mm_exp.acc_cyc + 2);
                    chk("grant_id", bus.o_grant_id, mm_exp.id);
                    chk("master_data", bus.o_master_data, mm_exp.data);
                    chk("master_cpol", bus.o_master_cpol, mm_exp.cpol);
                    chk("master_cpha", bus.o_master_cpha, mm_exp.cpha);
                    chk("master_div", bus.o_master_divider, mm_exp.div);
                end
                mm_tx   = bus.o_master_data;
                mm_cpol = bus.o_master_cpol;
                mm_cpha = bus.o_master_cpha;
                mm_div  = bus.o_master_divider;
                mm_cnt  = 4 + int'(bus.o_master_divider[1:0]);
                mm_busy = 1'b1;
            end
        end
    end

    // Response / chip-select / config-stability monitor
    logic [N-1:0] exp_cs;
    always @(negedge clock) begin
        #2;
        if (bus.o_rsp_valid != '0) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", bus.o_rsp_valid, '0);
            end else begin
                mon_exp = rsp_q.pop_front();
                chk("rsp_valid_onehot", bus.o_rsp_valid, N'(1) << mon_exp.id);
                chk("rsp_data", bus.o_rsp_data, mon_exp.rx);
                chk("rsp_timing", cyc, last_done_cyc + 1);
            end
        end
        exp_cs = '1;
        if (!reset && !bus.i_master_cs_n) exp_cs[cur_grant] = 1'b0;
        chk("cs_n", bus.o_cs_n, exp_cs);
        if (mm_busy) begin
            chk("cfg_stable_busy", {bus.o_master_cpol, bus.o_master_cpha, bus.o_master_divider, bus.o_master_data},
                {mm_cpol, mm_cpha, mm_div, mm_tx});
            chk("busy_in_xfer", bus.o_busy, 1'b1);
        end
    end

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            bus.i_req_valid[k]              = pend[k];
            bus.i_req_data[k*DW +: DW]      = r_data[k];
            bus.i_req_cpol[k]               = r_cpol[k];
            bus.i_req_cpha[k]               = r_cpha[k];
            bus.i_req_divider[k*CW +: CW]   = r_div[k];
        end
    endtask

    task automatic set_req(input int k, input logic [7:0] d, input bit cp, input bit ch, input logic [3:0] dv);
        pend[k]   = 1'b1;
        r_data[k] = d;
        r_cpol[k] = cp;
        r_cpha[k] = ch;
        r_div[k]  = dv;
    endtask

    task automatic step();
        int           exp_id;
        int           hs;
        logic [N-1:0] exp_rdy;
        @(negedge clock);
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                acc[k]  = 1'b0;
                pend[k] = 1'b0;
                if (remaining[k] > 0) begin
                    remaining[k]--;
                    set_req(k, 8'($urandom), r_cpol[k], r_cpha[k], 4'($urandom));
                end
            end
        end
        if (rand_mode) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(k, 8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
                end else if ($urandom_range(0, 19) == 0) begin
                    pend[k] = 1'b0;
                end
            end
        end
        drive();
        #2;
        exp_id  = -1;
        exp_rdy = '0;
        if (!reset && cyc >= arb_idle_at) exp_id = rr_pick(pend, rr_ptr);
        if (exp_id >= 0) exp_rdy[exp_id] = 1'b1;
        chk("req_ready", bus.o_req_ready, exp_rdy);
        hs = -1;
        if (!reset) begin
            for (int k = N - 1; k >= 0; k--)
                if (pend[k] && bus.o_req_ready[k]) hs = k;
        end
        if (hs >= 0) begin
            cfg_q.push_back('{hs, r_data[hs], r_cpol[hs], r_cpha[hs], r_div[hs], cyc});
            rsp_q.push_back('{hs, ~r_data[hs]});
            grant_log.push_back(hs);
            rr_ptr      = hs;
            cur_grant   = hs;
            arb_idle_at = NEVER;
            acc[hs]     = 1'b1;
        end
    endtask

    task automatic do_reset(input int n);
        #1;
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            pend[k]      = 1'b0;
            acc[k]       = 1'b0;
            remaining[k] = 0;
        end
        cfg_q.delete();
        rsp_q.delete();
        rr_ptr      = N - 1;
        arb_idle_at = 0;
        cur_grant   = 0;
        repeat (n) step();
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int  b;
        bit  idle;
        b = budget;
        idle = 1'b0;
        while (!idle && b > 0) begin
            step();
            b--;
            idle = !mm_busy && cfg_q.size() == 0 && rsp_q.size() == 0 && cyc >= arb_idle_at;
            for (int k = 0; k < N; k++) if (pend[k] || remaining[k] != 0) idle = 1'b0;
        end
        chk("drain_timeout", idle, 1'b1);
    endtask

    int exp_seq[6];
    int b;

    initial begin
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0; acc[k] = 1'b0; remaining[k] = 0;
            r_data[k] = '0; r_cpol[k] = 1'b0; r_cpha[k] = 1'b0; r_div[k] = '0;
        end
        drive();
        do_reset(3);

        // reset state
        step();
        chk("rst_cs_n", bus.o_cs_n, 2'b11);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_rsp_valid", bus.o_rsp_valid, 2'b00);
        chk("rst_enable", bus.o_master_enable, 1'b0);
        chk("rst_grant_id", bus.o_grant_id, 1'b0);
        chk("rst_master_cfg", {bus.o_master_cpol, bus.o_master_cpha, bus.o_master_divider, bus.o_master_data}, '0);

        // single request from requester 0
        grant_log.delete();
        set_req(0, 8'h96, 1'b1, 1'b1, 4'd15);
        wait_drain(200);
        chk("t1_grant_count", grant_log.size(), 1);
        if (grant_log.size() > 0) chk("t1_grant", grant_log[0], 0);

        // both requesters held valid from reset, alternating modes
        do_reset(2);
        grant_log.delete();
        set_req(0, 8'($urandom), 1'b1, 1'b0, 4'($urandom));
        set_req(1, 8'($urandom), 1'b0, 1'b0, 4'($urandom));
        remaining[0] = 2;
        remaining[1] = 2;
`ifdef SPI_ARB_PRIORITY_EN
        exp_seq = '{0, 0, 0, 1, 1, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1};
`endif
        wait_drain(400);
        chk("t2_grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size()) chk($sformatf("t2_grant_%0d", i), grant_log[i], exp_seq[i]);

        // reset while BUSY
        set_req(0, 8'h3C, 1'b0, 1'b1, 4'd2);
        b = 60;
        while (!mm_busy && b > 0) begin
            step();
            b--;
        end
        chk("t5_reach_busy", mm_busy, 1'b1);
        step();
        step();
        do_reset(3);
        step();
        chk("t5_cs_n", bus.o_cs_n, 2'b11);
        chk("t5_busy", bus.o_busy, 1'b0);
        chk("t5_rsp_valid", bus.o_rsp_valid, 2'b00);
        grant_log.delete();
        set_req(1, 8'hA5, 1'b1, 1'b0, 4'd7);
        wait_drain(200);
        chk("t5_grant_count", grant_log.size(), 1);
        if (grant_log.size() > 0) chk("t5_grant", grant_log[0], 1);

        // randomized traffic with withdrawals
        rand_mode = 1'b1;
        repeat (500) step();
        rand_mode = 1'b0;
        wait_drain(800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
